// File: rtl/md5_range_chunk_generator.sv
// ============================================================================
// md5_range_chunk_generator
// Enumerates every string over the byte range [min, max] in order of
// increasing length and emits one padded 512-bit MD5 block per clock.
// Optional build macro: GEN_WRAP_EN (restart enumeration on exhaustion).
// Rev 1.0
// ============================================================================
`default_nettype none

module md5_range_chunk_generator #(
    parameter int START_LEN = 1,
    parameter int MAX_LEN   = 8
) (
    input  logic         clk,
    input  logic         reset2,
    input  logic [7:0]   min,
    input  logic [7:0]   max,
    input  logic         run,
    output logic [511:0] chunk,
    output logic         valid,
    output logic [4:0]   len,
    output logic         done,
    output logic         range_err
);

    localparam logic [4:0] c_START_LEN = 5'(START_LEN);
    localparam logic [4:0] c_MAX_LEN   = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                   r_state;
    logic [7:0]               r_lo;
    logic [7:0]               r_hi;
    logic [8*MAX_LEN-1:0]     r_digits;

    logic [8*MAX_LEN-1:0]     w_inc_digits;
    logic [8*MAX_LEN-1:0]     w_all_lo;
    logic [8*MAX_LEN-1:0]     w_all_min;
    logic                     w_carry;

    assign w_all_lo  = {MAX_LEN{r_lo}};
    assign w_all_min = {MAX_LEN{min}};

    // Pads the active digits into a full MD5 block: data, 0x80, zeros, bit length.
    function automatic logic [511:0] build_chunk(
        input logic [8*MAX_LEN-1:0] d,
        input logic [4:0]           l
    );
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < l) begin
                b[8*i +: 8] = d[8*i +: 8];
            end
        end
        b[{l, 3'b000} +: 8] = 8'h80;
        b[511:448]          = {56'd0, l, 3'b000};
        return b;
    endfunction

    // Odometer increment over the active digits; w_carry set means the
    // carry left digit L-1 and this length is exhausted.
    always_comb begin
        w_inc_digits = r_digits;
        w_carry      = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < len && w_carry) begin
                if (r_digits[8*i +: 8] == r_hi) begin
                    w_inc_digits[8*i +: 8] = r_lo;
                end else begin
                    w_inc_digits[8*i +: 8] = r_digits[8*i +: 8] + 8'd1;
                    w_carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            r_state   <= S_RESET;
            r_lo      <= 8'd0;
            r_hi      <= 8'd0;
            r_digits  <= '0;
            chunk     <= '0;
            valid     <= 1'b0;
            len       <= 5'd0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (r_state)
                // The first edge after release performs the load, so the
                // first candidate appears without an extra idle cycle.
                S_RESET, S_LOAD: begin
                    r_lo <= min;
                    r_hi <= max;
                    if (min > max) begin
                        range_err <= 1'b1;
                        valid     <= 1'b0;
                        r_state   <= S_ERR;
                    end else begin
                        r_digits <= w_all_min;
                        len      <= c_START_LEN;
                        chunk    <= build_chunk(w_all_min, c_START_LEN);
                        valid    <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    done <= 1'b0;
                    if (run) begin
                        if (!w_carry) begin
                            r_digits <= w_inc_digits;
                            chunk    <= build_chunk(w_inc_digits, len);
                        end else if (len < c_MAX_LEN) begin
                            r_digits <= w_all_lo;
                            len      <= len + 5'd1;
                            chunk    <= build_chunk(w_all_lo, len + 5'd1);
                        end else begin
`ifdef GEN_WRAP_EN
                            r_digits <= w_all_lo;
                            len      <= c_START_LEN;
                            chunk    <= build_chunk(w_all_lo, c_START_LEN);
                            done     <= 1'b1;
`else
                            done    <= 1'b1;
                            valid   <= 1'b0;
                            r_state <= S_DONE;
`endif
                        end
                    end
                end

                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md5_range_chunk_generator.sv
// ============================================================================
// tb_md5_range_chunk_generator
// Directed plus randomized checks of md5_range_chunk_generator against an
// index-based model of the enumeration order. Rev 1.0
// ============================================================================
`default_nettype none

module tb_md5_range_chunk_generator;

    logic         clk;
    logic         reset2;
    logic [7:0]   tb_min;
    logic [7:0]   tb_max;
    logic         tb_run;

    logic [511:0] u1_chunk, u2_chunk, u3_chunk;
    logic         u1_valid, u2_valid, u3_valid;
    logic [4:0]   u1_len, u2_len, u3_len;
    logic         u1_done, u2_done, u3_done;
    logic         u1_err, u2_err, u3_err;

    int n_assert = 0;
    int n_fail   = 0;

    md5_range_chunk_generator #(.START_LEN(1), .MAX_LEN(2)) u1 (
        .clk(clk), .reset2(reset2), .min(tb_min), .max(tb_max), .run(tb_run),
        .chunk(u1_chunk), .valid(u1_valid), .len(u1_len), .done(u1_done), .range_err(u1_err)
    );
    md5_range_chunk_generator #(.START_LEN(1), .MAX_LEN(3)) u2 (
        .clk(clk), .reset2(reset2), .min(tb_min), .max(tb_max), .run(tb_run),
        .chunk(u2_chunk), .valid(u2_valid), .len(u2_len), .done(u2_done), .range_err(u2_err)
    );
    md5_range_chunk_generator #(.START_LEN(1), .MAX_LEN(16)) u3 (
        .clk(clk), .reset2(reset2), .min(tb_min), .max(tb_max), .run(tb_run),
        .chunk(u3_chunk), .valid(u3_valid), .len(u3_len), .done(u3_done), .range_err(u3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Candidate k of a START_LEN=1 enumeration over n symbols starting at lo:
    // strip whole lengths off k, then read the remainder in base n, digit 0 first.
    function automatic logic [511:0] model_chunk(input int lo, input int n, input int maxl,
                                                 input int k, output int l);
        int           off;
        int           cnt;
        logic [511:0] c;
        off = k;
        cnt = n;
        l   = 1;
        c   = '0;
        while (off >= cnt && l < maxl) begin
            off = off - cnt;
            l   = l + 1;
            cnt = cnt * n;
        end
        for (int i = 0; i < l; i++) begin
            c[8*i +: 8] = 8'(lo + off % n);
            off = off / n;
        end
        c[8*l +: 8] = 8'h80;
        c[511:448]  = 64'(l * 8);
        return c;
    endfunction

    task automatic restart(input logic [7:0] mn, input logic [7:0] mx);
        reset2 = 1'b1;
        tb_min = mn;
        tb_max = mx;
        tb_run = 1'b1;
        tick();
        reset2 = 1'b0;
    endtask

    initial begin
        logic [511:0] exp;
        int           el;
        int           lo, n, tot, k;
        logic         fin, dn, r;

        reset2 = 1'b1;
        tb_min = 8'h61;
        tb_max = 8'h63;
        tb_run = 1'b1;
        #2;
        check("rst_chunk", u1_chunk, '0);
        check("rst_valid", u1_valid, '0);
        check("rst_len",   u1_len,   '0);
        check("rst_done",  u1_done,  '0);
        check("rst_err",   u1_err,   '0);

        // Full enumeration of a..cc, then exhaustion behaviour.
        tick();
        reset2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = model_chunk(8'h61, 3, 2, i, el);
            check($sformatf("abc_chunk%0d", i), u1_chunk, exp);
            check($sformatf("abc_len%0d", i), u1_len, 512'(el));
            check($sformatf("abc_valid%0d", i), u1_valid, 1'b1);
            check($sformatf("abc_done%0d", i), u1_done, 1'b0);
            if (i == 0) begin
                check("cand0_lo16", u1_chunk[15:0], 16'h8061);
                check("cand0_bits", u1_chunk[511:448], 64'd8);
            end
            if (i == 4) begin
                check("cand4_lo24", u1_chunk[23:0], 24'h806162);
                check("cand4_bits", u1_chunk[511:448], 64'd16);
                check("cand4_len",  u1_len, 5'd2);
            end
        end
`ifdef GEN_WRAP_EN
        tick();
        check("wrap_chunk", u1_chunk, model_chunk(8'h61, 3, 2, 0, el));
        check("wrap_done",  u1_done, 1'b1);
        check("wrap_valid", u1_valid, 1'b1);
        tick();
        check("wrap_done_clr", u1_done, 1'b0);
        check("wrap_next", u1_chunk, model_chunk(8'h61, 3, 2, 1, el));
`else
        exp = model_chunk(8'h61, 3, 2, 11, el);
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("exh_done%0d", i), u1_done, 1'b1);
            check($sformatf("exh_valid%0d", i), u1_valid, 1'b0);
            check($sformatf("exh_chunk%0d", i), u1_chunk, exp);
            check($sformatf("exh_len%0d", i), u1_len, 5'd2);
        end
`endif

        // Pause after candidate 2, then mid-run reset at candidate 7.
        restart(8'h61, 8'h63);
        for (int i = 0; i < 3; i++) tick();
        tb_run = 1'b0;
        exp = model_chunk(8'h61, 3, 2, 2, el);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_chunk%0d", i), u1_chunk, exp);
            check($sformatf("hold_valid%0d", i), u1_valid, 1'b1);
        end
        tb_run = 1'b1;
        tick();
        check("resume_aa", u1_chunk, model_chunk(8'h61, 3, 2, 3, el));
        check("resume_len", u1_len, 5'd2);
        for (int i = 4; i <= 7; i++) tick();
        check("cand7", u1_chunk, model_chunk(8'h61, 3, 2, 7, el));
        #2;
        reset2 = 1'b1;
        #1;
        check("async_chunk", u1_chunk, '0);
        check("async_valid", u1_valid, '0);
        check("async_len",   u1_len,   '0);
        tick();
        reset2 = 1'b0;
        tick();
        check("restart_a", u1_chunk, model_chunk(8'h61, 3, 2, 0, el));
        check("restart_valid", u1_valid, 1'b1);

        // Inverted range.
        restart(8'h7a, 8'h61);
        tick();
        check("err_flag",  u1_err, 1'b1);
        check("err_valid", u1_valid, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("err_sticky", u1_err, 1'b1);
        check("err_valid_hold", u1_valid, 1'b0);
        check("err_u3", u3_err, 1'b1);

        // Single-symbol range, one candidate per length.
        restart(8'h30, 8'h30);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("zero_chunk%0d", i), u2_chunk, model_chunk(8'h30, 1, 3, i, el));
            check($sformatf("zero_len%0d", i), u2_len, 5'(i + 1));
        end
        tick();
        check("zero_done", u2_done, 1'b1);
`ifdef GEN_WRAP_EN
        check("zero_wrap", u2_chunk, model_chunk(8'h30, 1, 3, 0, el));
`else
        check("zero_valid", u2_valid, 1'b0);
`endif

        // Longest candidate.
        restart(8'h41, 8'h41);
        for (int i = 0; i < 16; i++) tick();
        check("max_len", u3_len, 5'd16);
        check("max_bytes", u3_chunk[135:0], {8'h80, {16{8'h41}}});
        check("max_bits", u3_chunk[511:448], 64'd128);
        check("max_mid_zero", u3_chunk[447:136], '0);

        // Randomized ranges with random run gating; min/max wiggle after load.
        for (int t = 0; t < 4; t++) begin
            lo  = int'($urandom_range(32, 120));
            n   = int'($urandom_range(1, 4));
            tot = n + n * n + n * n * n;
            restart(8'(lo), 8'(lo + n - 1));
            tick();
            k   = 0;
            fin = 1'b0;
            check($sformatf("rnd%0d_first", t), u2_chunk, model_chunk(lo, n, 3, 0, el));
            for (int c = 0; c < tot + 15; c++) begin
                r      = ($urandom % 4) != 0;
                tb_run = r;
                tb_min = 8'($urandom);
                tb_max = 8'($urandom);
                tick();
                dn = 1'b0;
                if (r && !fin) begin
                    if (k == tot - 1) begin
`ifdef GEN_WRAP_EN
                        k  = 0;
                        dn = 1'b1;
`else
                        fin = 1'b1;
`endif
                    end else begin
                        k = k + 1;
                    end
                end
                exp = model_chunk(lo, n, 3, k, el);
                check($sformatf("rnd%0d_chunk_c%0d", t, c), u2_chunk, exp);
                check($sformatf("rnd%0d_len_c%0d", t, c), u2_len, 5'(el));
                check($sformatf("rnd%0d_valid_c%0d", t, c), u2_valid, !fin);
                check($sformatf("rnd%0d_done_c%0d", t, c), u2_done, fin | dn);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md5_range_chunk_generator.md
# md5_range_chunk_generator

Upstream feeder for the MD5 brute-force datapath. It enumerates every candidate string whose bytes lie in an inclusive range [min, max], in order of increasing length. For each candidate it emits one fully padded 512-bit MD5 message block per clock. The brute-forcer pipes `chunk` into the MD5 core and delays `chunk[127:0]` alongside it to recover the matching plaintext.

## Interface
Parameters:
- START_LEN, 1: candidate length after reset; legal 1..MAX_LEN.
- MAX_LEN, 8: longest candidate length; legal 1..16.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset2  in  1  asynchronous, active-high reset.
- min  in  8  lowest byte value; sampled once, in LOAD.
- max  in  8  highest byte value; sampled once, in LOAD.
- run  in  1  1 = advance one candidate per clock; 0 = hold all outputs.
- chunk  out  512  padded MD5 block for the current candidate.
- valid  out  1  `chunk` holds a legal candidate.
- len  out  5  byte length of the current candidate.
- done  out  1  enumeration exhausted (sticky).
- range_err  out  1  sampled min > max (sticky).

## Operation
- Reset values of all outputs are 0.
- Internal state: odometer of MAX_LEN 8-bit digits; captured `lo` and `hi`; current length L.
- Digit 0 is the least significant digit and maps to message byte 0. The first character changes fastest.
- Chunk layout, rebuilt from (digits, L) every time the candidate changes:
  - bytes 0..L-1 hold the digits: byte i = `chunk[8i+7:8i]`.
  - byte L = 0x80.
  - bytes L+1..55 = 0.
  - `chunk[511:448]` = L*8, the 64-bit little-endian bit length.
- FSM states: RESET, LOAD, RUN, DONE, ERR.
  - RESET → LOAD: on the first clock after reset2 deasserts.
  - LOAD: capture lo=min and hi=max. If lo > hi, go to ERR and set range_err=1, valid=0. Otherwise set all digits=lo, L=START_LEN, present the first chunk, set valid=1, and go to RUN. LOAD ignores `run`.
  - RUN with run=1, incrementing digit 0 with carry:
    - A digit equal to hi wraps to lo and carries into the next digit.
    - If the carry leaves digit L-1 and L < MAX_LEN: L increments and all digits are set to lo.
    - If the carry leaves digit L-1 and L == MAX_LEN: exhaustion (see Configuration).
  - RUN with run=0: chunk, len and valid hold.
  - DONE and ERR are terminal until reset2.
- lo == hi is legal: each length produces exactly one candidate.
- The total candidate count is the sum over L=START_LEN..MAX_LEN of (hi-lo+1)^L.

## Timing
- The first valid chunk appears on the first rising edge after reset2 deasserts, at the LOAD exit.
- Candidate k (0-based) is registered on edge k+1 when run stays high.
- Throughput is 1 candidate per clock, with no bubbles at length transitions.
- chunk, len, valid and done are registered outputs with no combinational path from inputs.
- Changes to min/max after LOAD have no effect until the next reset2.
- reset2 asserted mid-run clears all state immediately, asynchronously. Enumeration restarts from the beginning after release.
- The `run` deassert/assert effect is visible on the next edge.

## Configuration
- Macro `GEN_WRAP_EN`.
- Defined: on exhaustion, the generator restarts at L=START_LEN with all digits=lo on the same edge. `done` pulses high for that one cycle only, and valid stays 1.
- Undefined: on exhaustion, go to DONE. `done` is set sticky, valid=0, and chunk/len hold the last candidate.

## Test plan
- min=0x61, max=0x63, START_LEN=1, MAX_LEN=2, run=1 → 12 candidates in order: a, b, c, aa, ba, ca, ab, bb, cb, ac, bc, cc. Check candidate 0: `chunk[15:0]`=0x8061, `chunk[511:448]`=8. Check candidate 4: `chunk[23:0]`=0x806162, `chunk[511:448]`=16, len=2.
- Same configuration, macro undefined → after "cc", done=1 and valid=0 on the next edge, with chunk unchanged for 10 further cycles. With macro defined → "a" follows "cc", done is high for exactly 1 cycle, and valid stays 1.
- min=0x7a, max=0x61 → range_err=1 and valid=0 one edge after release, and the state stays ERR for 20 cycles.
- min=max=0x30, MAX_LEN=3 → "0", "00", "000" on consecutive edges with len=1, 2, 3, then done.
- Drop `run` for 5 cycles after candidate 2 → chunk holds "c" for all 5 cycles, then "aa" follows. Separately, assert reset2 for 1 cycle at candidate 7 → all outputs go to 0 immediately, and "a" reappears one edge after release.
- MAX_LEN=16, min=max=0x41 → the final chunk has bytes 0..15 = 0x41, byte 16 = 0x80, and `chunk[511:448]`=128.
